ma_issue_sched: RTL and testbench
=================================

# ma_issue_sched

Issue scheduler for the shared multiply-add unit. It arbitrates round-robin between `NUM_REQ` requesters and issues at most one operation per cycle. It tracks adder-input and writeback occupancy so that ADD, MLT and chained MAC/MAD results never collide on the unit's single result port. It also assigns the issue number carried with each operation, and sits between the lane dispatch stage and the MA unit's `I_En/I_Op/I_Issue_No` inputs.

## Interface
- `NUM_REQ`, 2, number of requesters (≥2)
- `DEPTH_MLT`, 3, multiplier latency in cycles (≥1)
- `DEPTH_ADD`, 1, adder latency in cycles (≥1)
- `WIDTH_ISSUE`, 8, issue-number width
- `clock`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `I_Stall`  in  1  MA pipeline frozen this cycle
- `I_Req`  in  NUM_REQ  request, held until granted
- `I_OpClass`  in  NUM_REQ×2  per-requester op class
- `I_OpCode`  in  NUM_REQ×2  per-requester op code
- `O_Grant`  out  NUM_REQ  one-hot grant, combinational
- `O_En`  out  1  issue valid to MA unit (= `|O_Grant`)
- `O_Sel`  out  $clog2(NUM_REQ)  index of granted requester
- `O_Issue_No`  out  WIDTH_ISSUE  issue number of the granted op
- `O_Busy`  out  1  any reservation outstanding
- `O_Illegal`  out  1  some active request has an illegal class

## Operation
- **Op types and latencies**
  - ADD: class 00, any opcode. Uses the adder at offset 0; writeback at `DEPTH_ADD`.
  - MLT: class 01 with opcode 0x. Writeback at `DEPTH_MLT`.
  - MAC/MAD: class 01 with opcode 1x. Uses the adder at offset `DEPTH_MLT`; writeback at `DEPTH_MLT+DEPTH_ADD`.
  - Class 1x is illegal: never eligible, and drives `O_Illegal=1` while requested.
- **Reservation vectors**
  - `Rsv_WB` and `Rsv_Add`, each `L=DEPTH_MLT+DEPTH_ADD+1` bits.
  - Bit j means the resource is occupied j cycles from now.
- **Eligibility**
  - ADD: `!Rsv_Add[0] & !Rsv_WB[DEPTH_ADD]`.
  - MLT: `!Rsv_WB[DEPTH_MLT]`.
  - MAC/MAD: `!Rsv_Add[DEPTH_MLT] & !Rsv_WB[DEPTH_MLT+DEPTH_ADD]`.
- **Arbitration**
  - Round-robin among eligible requesters, searching from `Ptr`.
  - On grant, `Ptr` ← granted index + 1 (mod `NUM_REQ`). `Ptr` is unchanged otherwise.
  - An ineligible requester is skipped; it does not block lower-priority eligible ones.
- **Update on a non-stalled clock**
  - Each vector ← `vector >> 1`.
  - On grant, OR in bit (offset−1) for each resource the op uses.
  - Bit 0 falls off each cycle.
- **Issue number**
  - `Issue_Cnt` drives `O_Issue_No` and increments by 1 per grant, wrapping modulo 2^WIDTH_ISSUE.
  - `O_Issue_No` is only meaningful when `O_En=1`.
- **Stall:** while `I_Stall=1`, `O_Grant=0` and all state (vectors, `Ptr`, `Issue_Cnt`) holds.
- **Reset:** clears all state, so `Ptr=0` and `Issue_Cnt=0`. While `reset=1`, all outputs are forced to 0. Reset mid-operation discards reservations; in-flight MA results are the MA unit's concern.
- `O_Busy` = `|Rsv_WB | |Rsv_Add`.

## Timing
- Grant is combinational in the request cycle. The requester samples `O_Grant` and drops or replaces its request on the next edge.
- An op granted in cycle t presents its result at the MA output in cycle t+latency. Two grants never produce results in the same cycle.
- Throughput is one grant per cycle. Back-to-back MLT, and ADD followed by MLT, need no bubble.
- Reset is sampled at the clock edge; the first grant is possible in the cycle after `reset` falls.

## Structure
- Add to `pkg_tpu`:
  - `issue_no_t` with width `WIDTH_ISSUE`.
  - An enum `ma_kind_t` {ADD, MLT, MAC, ILL}.
  - Constants for the class/opcode decode.
- One sub-module, `rr_arbiter`: a parameterised round-robin arbiter with `I_Req`, `I_Ptr`, `O_Grant`, `O_Sel`, `O_Valid`. It is reusable elsewhere.
- Decode, eligibility, reservation vectors and the counter stay in `ma_issue_sched`.

## Test plan
All scenarios use `NUM_REQ=2`, `DEPTH_MLT=3`, `DEPTH_ADD=1`, `WIDTH_ISSUE=3`.
- **Reset:** hold reset 3 cycles with all requests high → all outputs 0. First grant after release goes to req0 with `O_Issue_No=0`.
- **Writeback hazard:** req0 MLT at t0 (granted, writeback at t3); req1 ADD from t2 → no grant at t2, granted at t3 with `O_Issue_No=1`.
- **Adder hazard:** req0 MAC at t0 (adder at t3, writeback at t4); req1 ADD at t3 → blocked at t3, granted at t4 (writeback at t5); `O_Busy` falls after t5.
- **Fairness:** both requesters issue ADD every cycle → grants 0,1,0,1,…; `O_Issue_No` counts 0..7 then wraps to 0.
- **Stall:** under back-to-back ADD, `I_Stall` high for 2 cycles → `O_Grant=0`, `O_Busy` and `Ptr` frozen. Grants resume with the next requester in order.
- **Illegal op:** req0 class 10, req1 MLT → `O_Illegal=1`; req1 granted every eligible cycle, req0 never granted.

Source files
------------

// File: rtl/ma_issue_sched_pkg.sv
// ma_issue_sched_pkg: shared types and decode helpers for the multiply-add
// issue scheduler.
//   issue_no_t  - issue number at the default width
//   ma_kind_t   - decoded operation kind {ADD, MLT, MAC, ILL}
//   ma_decode() - class/opcode to ma_kind_t
package ma_issue_sched_pkg;

  localparam int unsigned ISSUE_W_DEFAULT = 8;

  typedef logic [ISSUE_W_DEFAULT-1:0] issue_no_t;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    MLT = 2'd1,
    MAC = 2'd2,
    ILL = 2'd3
  } ma_kind_t;

  // Operation class field
  localparam logic [1:0] CLS_ADD = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  // Multiply opcodes at or above this value chain into the adder (MAC/MAD)
  localparam logic [1:0] OPC_CHAIN_MIN = 2'b10;

  function automatic ma_kind_t ma_decode(input logic [1:0] op_class,
                                         input logic [1:0] op_code);
    if (op_class == CLS_ADD)
      return ADD;
    else if (op_class == CLS_MUL)
      return (op_code >= OPC_CHAIN_MIN) ? MAC : MLT;
    else
      return ILL;
  endfunction

endpackage

// File: rtl/ma_issue_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   I_Req   - request vector
//   I_Ptr   - highest-priority index for this cycle
//   O_Grant - one-hot grant (zero when no request)
//   O_Sel   - index of the granted requester (zero when no request)
//   O_Valid - some request was granted
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         I_Req,
  input  logic [$clog2(NUM_REQ)-1:0] I_Ptr,
  output logic [NUM_REQ-1:0]         O_Grant,
  output logic [$clog2(NUM_REQ)-1:0] O_Sel,
  output logic                       O_Valid
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  int unsigned      pos;
  logic [SEL_W-1:0] idx;

  // Walk the requesters starting at I_Ptr and wrapping; the first hit wins.
  always_comb begin
    O_Grant = '0;
    O_Sel   = '0;
    O_Valid = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(I_Ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = SEL_W'(pos);
      if (!O_Valid && I_Req[idx]) begin
        O_Valid      = 1'b1;
        O_Grant[idx] = 1'b1;
        O_Sel        = idx;
      end
    end
  end

endmodule

// File: rtl/ma_issue_sched.sv
// ma_issue_sched: issue scheduler for the shared multiply-add unit.
// Round-robin arbitration among requesters, with adder and writeback
// reservation vectors so no two ops ever produce results in the same cycle.
//   clock, reset  - clock, synchronous active-high reset
//   I_Stall       - MA pipeline frozen: no grant, all state holds
//   I_Req         - per-requester request (held until granted)
//   I_OpClass     - per-requester op class, 2 bits each
//   I_OpCode      - per-requester op code, 2 bits each
//   O_Grant/O_En/O_Sel - one-hot grant, issue valid, granted index
//   O_Issue_No    - issue number of the granted op
//   O_Busy        - some reservation outstanding
//   O_Illegal     - an active request carries an illegal class
module ma_issue_sched
  import ma_issue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DEPTH_MLT   = 3,
  parameter int unsigned DEPTH_ADD   = 1,
  parameter int unsigned WIDTH_ISSUE = ISSUE_W_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Stall,
  input  logic [NUM_REQ-1:0]         I_Req,
  input  logic [2*NUM_REQ-1:0]       I_OpClass,
  input  logic [2*NUM_REQ-1:0]       I_OpCode,
  output logic [NUM_REQ-1:0]         O_Grant,
  output logic                       O_En,
  output logic [$clog2(NUM_REQ)-1:0] O_Sel,
  output logic [WIDTH_ISSUE-1:0]     O_Issue_No,
  output logic                       O_Busy,
  output logic                       O_Illegal
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);
  localparam int unsigned L     = DEPTH_MLT + DEPTH_ADD + 1;

  // Bit j set: resource occupied j cycles from now.
  logic [L-1:0]           rsv_wb, rsv_add;
  logic [L-1:0]           wb_next, add_next;
  logic [SEL_W-1:0]       ptr, ptr_next;
  logic [WIDTH_ISSUE-1:0] issue_cnt;

  ma_kind_t               kind [NUM_REQ];
  ma_kind_t               g_kind;
  logic [NUM_REQ-1:0]     elig, ill, cand, grant;
  logic [SEL_W-1:0]       sel;
  logic                   valid;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_dec
    assign kind[r] = ma_decode(I_OpClass[2*r +: 2], I_OpCode[2*r +: 2]);
    assign ill[r]  = (kind[r] == ILL);
    assign elig[r] = (kind[r] == ADD) ? (~rsv_add[0] & ~rsv_wb[DEPTH_ADD]) :
                     (kind[r] == MLT) ? ~rsv_wb[DEPTH_MLT] :
                     (kind[r] == MAC) ? (~rsv_add[DEPTH_MLT] & ~rsv_wb[L-1]) :
                                        1'b0;
  end

  // Ineligible requesters are masked before arbitration so they never block
  // lower-priority eligible ones.
  assign cand = I_Req & elig & {NUM_REQ{~(reset | I_Stall)}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .I_Req   (cand),
    .I_Ptr   (ptr),
    .O_Grant (grant),
    .O_Sel   (sel),
    .O_Valid (valid)
  );

  assign g_kind = kind[sel];

  // Reservations are recorded at (offset - 1) because the vectors shift as
  // the grant is registered. ADD's adder slot is offset 0, i.e. this cycle.
  always_comb begin
    wb_next  = rsv_wb >> 1;
    add_next = rsv_add >> 1;
    if (valid) begin
      case (g_kind)
        ADD: wb_next[DEPTH_ADD-1] = 1'b1;
        MLT: wb_next[DEPTH_MLT-1] = 1'b1;
        MAC: begin
          add_next[DEPTH_MLT-1]          = 1'b1;
          wb_next[DEPTH_MLT+DEPTH_ADD-1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ptr_next = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      rsv_wb    <= '0;
      rsv_add   <= '0;
      ptr       <= '0;
      issue_cnt <= '0;
    end else if (!I_Stall) begin
      rsv_wb  <= wb_next;
      rsv_add <= add_next;
      if (valid) begin
        ptr       <= ptr_next;
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  assign O_Grant    = grant;
  assign O_En       = valid;
  assign O_Sel      = sel;
  assign O_Issue_No = reset ? '0 : issue_cnt;
  assign O_Busy     = ~reset & ((|rsv_wb) | (|rsv_add));
  assign O_Illegal  = ~reset & (|(I_Req & ill));

endmodule

// File: tb/tb_ma_issue_sched.sv
// tb_ma_issue_sched: directed bench for ma_issue_sched with NUM_REQ=2,
// DEPTH_MLT=3, DEPTH_ADD=1, WIDTH_ISSUE=3. Inputs change on the falling
// edge; outputs are checked 1 time unit later, before the next rising edge.
module tb_ma_issue_sched;

  logic       clock;
  logic       reset;
  logic       I_Stall;
  logic [1:0] I_Req;
  logic [3:0] I_OpClass;
  logic [3:0] I_OpCode;
  logic [1:0] O_Grant;
  logic       O_En;
  logic [0:0] O_Sel;
  logic [2:0] O_Issue_No;
  logic       O_Busy;
  logic       O_Illegal;

  int vectors     = 0;
  int miscompares = 0;

  // {req1, req0} fields
  localparam logic [3:0] C_ADD2   = 4'b0000;   // both ADD
  localparam logic [3:0] C_MUL0   = 4'b0001;   // req0 class 01
  localparam logic [3:0] C_ILLMUL = 4'b0110;   // req0 class 10, req1 class 01
  localparam logic [3:0] O_MAC0   = 4'b0010;   // req0 opcode 10

  ma_issue_sched #(
    .NUM_REQ     (2),
    .DEPTH_MLT   (3),
    .DEPTH_ADD   (1),
    .WIDTH_ISSUE (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Stall    (I_Stall),
    .I_Req      (I_Req),
    .I_OpClass  (I_OpClass),
    .I_OpCode   (I_OpCode),
    .O_Grant    (O_Grant),
    .O_En       (O_En),
    .O_Sel      (O_Sel),
    .O_Issue_No (O_Issue_No),
    .O_Busy     (O_Busy),
    .O_Illegal  (O_Illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply(input logic rst, input logic stl, input logic [1:0] req,
                       input logic [3:0] cls, input logic [3:0] opc);
    @(negedge clock);
    reset     = rst;
    I_Stall   = stl;
    I_Req     = req;
    I_OpClass = cls;
    I_OpCode  = opc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; I_Stall = 1'b0; I_Req = '0; I_OpClass = '0; I_OpCode = '0;

    // Reset: all requests high, outputs forced low
    apply(1, 0, 2'b11, C_ADD2, 4'b0000);
    chk("rst0_grant", O_Grant, 0); chk("rst0_en", O_En, 0);
    apply(1, 0, 2'b11, C_ADD2, 4'b0000);
    chk("rst1_grant", O_Grant, 0); chk("rst1_issue", O_Issue_No, 0);
    apply(1, 0, 2'b11, 4'b1000, 4'b0000);
    chk("rst2_grant", O_Grant, 0); chk("rst2_sel", O_Sel, 0);
    chk("rst2_busy", O_Busy, 0);   chk("rst2_illegal", O_Illegal, 0);
    apply(0, 0, 2'b11, C_ADD2, 4'b0000);
    chk("first_grant", O_Grant, 2'b01); chk("first_en", O_En, 1);
    chk("first_sel", O_Sel, 0);         chk("first_issue", O_Issue_No, 0);
    chk("first_illegal", O_Illegal, 0);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("first_busy", O_Busy, 1); chk("first_idle_grant", O_Grant, 0);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("first_drain", O_Busy, 0);

    // Writeback hazard: MLT at t0 writes back at t3; ADD from t2 waits to t3
    apply(1, 0, 2'b00, C_ADD2, 4'b0000);
    apply(0, 0, 2'b01, C_MUL0, 4'b0000);
    chk("wbh_t0_grant", O_Grant, 2'b01); chk("wbh_t0_issue", O_Issue_No, 0);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("wbh_t1_busy", O_Busy, 1);
    apply(0, 0, 2'b10, C_ADD2, 4'b0000);
    chk("wbh_t2_grant", O_Grant, 0); chk("wbh_t2_en", O_En, 0);
    apply(0, 0, 2'b10, C_ADD2, 4'b0000);
    chk("wbh_t3_grant", O_Grant, 2'b10); chk("wbh_t3_sel", O_Sel, 1);
    chk("wbh_t3_issue", O_Issue_No, 1);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("wbh_t4_busy", O_Busy, 1);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("wbh_t5_busy", O_Busy, 0);

    // Adder hazard: MAC at t0 holds adder at t3; ADD waits to t4
    apply(1, 0, 2'b00, C_ADD2, 4'b0000);
    apply(0, 0, 2'b01, C_MUL0, O_MAC0);
    chk("addh_t0_grant", O_Grant, 2'b01);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("addh_t1_busy", O_Busy, 1);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    apply(0, 0, 2'b10, C_ADD2, 4'b0000);
    chk("addh_t3_grant", O_Grant, 0);
    apply(0, 0, 2'b10, C_ADD2, 4'b0000);
    chk("addh_t4_grant", O_Grant, 2'b10); chk("addh_t4_issue", O_Issue_No, 1);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("addh_t5_busy", O_Busy, 1);
    apply(0, 0, 2'b00, C_ADD2, 4'b0000);
    chk("addh_t6_busy", O_Busy, 0);

    // Fairness: alternating grants, issue number wraps at 8
    apply(1, 0, 2'b00, C_ADD2, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 2'b11, C_ADD2, 4'b0000);
      chk($sformatf("fair%0d_grant", i), O_Grant, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("fair%0d_issue", i), O_Issue_No, i % 8);
    end

    // Stall: two frozen cycles, then resume with req0 and issue 2
    apply(0, 1, 2'b11, C_ADD2, 4'b0000);
    chk("stall0_grant", O_Grant, 0); chk("stall0_busy", O_Busy, 1);
    apply(0, 1, 2'b11, C_ADD2, 4'b0000);
    chk("stall1_en", O_En, 0); chk("stall1_busy", O_Busy, 1);
    apply(0, 0, 2'b11, C_ADD2, 4'b0000);
    chk("resume0_grant", O_Grant, 2'b01); chk("resume0_issue", O_Issue_No, 2);
    apply(0, 0, 2'b11, C_ADD2, 4'b0000);
    chk("resume1_grant", O_Grant, 2'b10); chk("resume1_issue", O_Issue_No, 3);

    // Reset with reservations and count outstanding forces outputs low
    apply(1, 0, 2'b00, C_ADD2, 4'b0000);
    chk("midrst_busy", O_Busy, 0); chk("midrst_issue", O_Issue_No, 0);

    // Illegal op: req0 class 10 never granted, req1 MLT every cycle
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 2'b11, C_ILLMUL, 4'b0000);
      chk($sformatf("ill%0d_grant", i), O_Grant, 2'b10);
      chk($sformatf("ill%0d_flag", i), O_Illegal, 1);
      chk($sformatf("ill%0d_issue", i), O_Issue_No, i);
    end
    apply(0, 0, 2'b01, C_ILLMUL, 4'b0000);
    chk("ill_alone_grant", O_Grant, 0); chk("ill_alone_flag", O_Illegal, 1);
    apply(0, 0, 2'b00, 4'b1111, 4'b0000);
    chk("ill_noreq_flag", O_Illegal, 0); chk("ill_noreq_grant", O_Grant, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
